// File: rtl/rstack_pkg.sv
// ============================================================================
// Module : rstack_pkg
// Brief  : Shared defaults and op encoding for the CPU return stack.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package rstack_pkg;

    localparam int RS_DATA_WIDTH = 16;
    localparam int RS_DEPTH      = 16;
    localparam int RS_PTR_WIDTH  = $clog2(RS_DEPTH);

    // Operation decoded from {push, pop}
    typedef enum logic [1:0] {
        RS_NOP     = 2'b00,
        RS_POP     = 2'b01,
        RS_PUSH    = 2'b10,
        RS_REPLACE = 2'b11
    } rs_op_e;

endpackage

`default_nettype wire

// File: rtl/rstack_mem.sv
// ============================================================================
// Module : rstack_mem
// Brief  : Single-write, single-read register array holding the entries below TOS.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module rstack_mem
    import rstack_pkg::*;
#(
    parameter int DATA_WIDTH = RS_DATA_WIDTH,
    parameter int DEPTH      = RS_DEPTH,
    parameter int PTR_WIDTH  = RS_PTR_WIDTH
) (
    input  logic                  write_clock,
    input  logic                  wr_en,
    input  logic [PTR_WIDTH-1:0]  wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic [PTR_WIDTH-1:0]  rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    logic [DATA_WIDTH-1:0] r_mem [0:DEPTH-2];

    always_ff @(posedge write_clock) begin
        if (wr_en) begin
            r_mem[wr_addr] <= wr_data;
        end
    end

    // Read is combinational so a pop can load the next entry on the same edge.
    assign rd_data = r_mem[rd_addr];

endmodule

`default_nettype wire

// File: rtl/return_stack.sv
// ============================================================================
// Module : return_stack
// Brief  : Return stack with registered TOS, sticky error flags and an
//          optional halt request enabled by macro RSTACK_ERR_HALT_EN.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module return_stack
    import rstack_pkg::*;
#(
    parameter int DATA_WIDTH = RS_DATA_WIDTH,
    parameter int DEPTH      = RS_DEPTH,
    parameter int PTR_WIDTH  = RS_PTR_WIDTH
) (
    input  logic                  write_clock,
    input  logic                  reset,
    input  logic                  push,
    input  logic                  pop,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  clear_err,
    output logic [DATA_WIDTH-1:0] tos,
    output logic [PTR_WIDTH:0]    depth,
    output logic                  empty,
    output logic                  full,
    output logic                  overflow,
    output logic                  underflow,
    output logic                  halt_req
);

    localparam logic [PTR_WIDTH:0]   c_FULL_DEPTH = (PTR_WIDTH+1)'(DEPTH);
    localparam logic [PTR_WIDTH:0]   c_DEPTH_ONE  = (PTR_WIDTH+1)'(1);
    localparam logic [PTR_WIDTH-1:0] c_PTR_ONE    = PTR_WIDTH'(1);
    localparam logic [PTR_WIDTH-1:0] c_PTR_TWO    = PTR_WIDTH'(2);

    logic [DATA_WIDTH-1:0] r_tos;
    logic [PTR_WIDTH:0]    r_depth;
    logic                  r_overflow;
    logic                  r_underflow;

    rs_op_e                w_op;
    logic [DATA_WIDTH-1:0] w_nxt_tos;
    logic [PTR_WIDTH:0]    w_nxt_depth;
    logic                  w_empty;
    logic                  w_full;
    logic                  w_wr_en;
    logic                  w_ovf_evt;
    logic                  w_unf_evt;
    logic                  w_nxt_ovf;
    logic                  w_nxt_unf;
    logic [PTR_WIDTH-1:0]  w_wr_addr;
    logic [PTR_WIDTH-1:0]  w_rd_addr;
    logic [DATA_WIDTH-1:0] w_rd_data;

    assign w_empty = (r_depth == '0);
    assign w_full  = (r_depth == c_FULL_DEPTH);

    // Low-bit wrap makes depth==DEPTH read slot DEPTH-2, as required.
    assign w_wr_addr = r_depth[PTR_WIDTH-1:0] - c_PTR_ONE;
    assign w_rd_addr = r_depth[PTR_WIDTH-1:0] - c_PTR_TWO;

    always_comb begin
        w_op        = rs_op_e'({push, pop});
        w_nxt_tos   = r_tos;
        w_nxt_depth = r_depth;
        w_wr_en     = 1'b0;
        w_ovf_evt   = 1'b0;
        w_unf_evt   = 1'b0;
        case (w_op)
            RS_PUSH, RS_REPLACE: begin
                if (w_op == RS_REPLACE && !w_empty) begin
                    w_nxt_tos = push_data;
                end else if (w_full) begin
                    w_ovf_evt = 1'b1;
                end else begin
                    w_wr_en     = !w_empty;
                    w_nxt_tos   = push_data;
                    w_nxt_depth = r_depth + c_DEPTH_ONE;
                end
            end
            RS_POP: begin
                if (w_empty) begin
                    w_unf_evt = 1'b1;
                end else if (r_depth == c_DEPTH_ONE) begin
                    w_nxt_tos   = '0;
                    w_nxt_depth = '0;
                end else begin
                    w_nxt_tos   = w_rd_data;
                    w_nxt_depth = r_depth - c_DEPTH_ONE;
                end
            end
            default: ;
        endcase
    end

    // An error event in the same cycle as clear_err keeps the flag set.
    assign w_nxt_ovf = w_ovf_evt | (r_overflow  & ~clear_err);
    assign w_nxt_unf = w_unf_evt | (r_underflow & ~clear_err);

    always_ff @(posedge write_clock) begin
        if (reset) begin
            r_tos       <= '0;
            r_depth     <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            r_tos       <= w_nxt_tos;
            r_depth     <= w_nxt_depth;
            r_overflow  <= w_nxt_ovf;
            r_underflow <= w_nxt_unf;
        end
    end

    rstack_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .PTR_WIDTH  (PTR_WIDTH)
    ) u_mem (
        .write_clock (write_clock),
        .wr_en       (w_wr_en),
        .wr_addr     (w_wr_addr),
        .wr_data     (r_tos),
        .rd_addr     (w_rd_addr),
        .rd_data     (w_rd_data)
    );

`ifdef RSTACK_ERR_HALT_EN
    logic r_halt;

    always_ff @(posedge write_clock) begin
        if (reset) begin
            r_halt <= 1'b0;
        end else begin
            r_halt <= w_nxt_ovf | w_nxt_unf;
        end
    end

    assign halt_req = r_halt;
`else
    assign halt_req = 1'b0;
`endif

    assign tos       = r_tos;
    assign depth     = r_depth;
    assign empty     = w_empty;
    assign full      = w_full;
    assign overflow  = r_overflow;
    assign underflow = r_underflow;

endmodule

`default_nettype wire

// File: tb/tb_return_stack.sv
// ============================================================================
// Module : tb_return_stack
// Brief  : Table-driven scoreboard bench for return_stack plus PC/return and
//          mid-sequence reset sequences.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_return_stack;

    typedef struct packed {
        logic [15:0] tos;
        logic [4:0]  depth;
        logic        empty;
        logic        full;
        logic        ovf;
        logic        unf;
        logic        halt;
    } out_t;

    typedef struct {
        logic        rst;
        logic        push;
        logic        pop;
        logic        clr;
        logic [15:0] data;
        out_t        exp;
    } vec_t;

    logic        write_clock = 1'b0;
    logic        reset       = 1'b1;
    logic        push        = 1'b0;
    logic        pop         = 1'b0;
    logic [15:0] push_data   = '0;
    logic        clear_err   = 1'b0;
    logic [15:0] tos;
    logic [4:0]  depth;
    logic        empty, full, overflow, underflow, halt_req;

    logic        is_return = 1'b0;
    logic [15:0] pc        = '0;

    int   n_vec  = 0;
    int   n_miss = 0;
    vec_t vecs[$];
    out_t exp_q[$];

    return_stack dut (
        .write_clock (write_clock),
        .reset       (reset),
        .push        (push),
        .pop         (pop),
        .push_data   (push_data),
        .clear_err   (clear_err),
        .tos         (tos),
        .depth       (depth),
        .empty       (empty),
        .full        (full),
        .overflow    (overflow),
        .underflow   (underflow),
        .halt_req    (halt_req)
    );

    always #5 write_clock = ~write_clock;

    // Program counter consumer: loads Tbus on a return.
    always_ff @(posedge write_clock) begin
        if (is_return) pc <= tos;
    end

    function automatic out_t mk(input logic [15:0] t, input logic [4:0] d,
                                input logic o, input logic u);
        out_t r;
        r.tos   = t;
        r.depth = d;
        r.empty = (d == 5'd0);
        r.full  = (d == 5'd16);
        r.ovf   = o;
        r.unf   = u;
`ifdef RSTACK_ERR_HALT_EN
        r.halt  = o | u;
`else
        r.halt  = 1'b0;
`endif
        return r;
    endfunction

    function automatic void add(input logic rs, input logic pu, input logic po,
                                input logic cl, input logic [15:0] dt, input out_t e);
        vec_t v;
        v.rst = rs; v.push = pu; v.pop = po; v.clr = cl; v.data = dt; v.exp = e;
        vecs.push_back(v);
    endfunction

    function automatic out_t sample();
        out_t g;
        g.tos = tos; g.depth = depth; g.empty = empty; g.full = full;
        g.ovf = overflow; g.unf = underflow; g.halt = halt_req;
        return g;
    endfunction

    task automatic chk(input string name, input out_t got, input out_t exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got tos=%h depth=%0d e=%b f=%b ovf=%b unf=%b halt=%b, want tos=%h depth=%0d e=%b f=%b ovf=%b unf=%b halt=%b",
                     name, got.tos, got.depth, got.empty, got.full, got.ovf, got.unf, got.halt,
                     exp.tos, exp.depth, exp.empty, exp.full, exp.ovf, exp.unf, exp.halt);
        end
    endtask

    task automatic step(input logic rs, input logic pu, input logic po,
                        input logic cl, input logic [15:0] dt, input logic ret);
        @(negedge write_clock);
        reset = rs; push = pu; pop = po; clear_err = cl; push_data = dt; is_return = ret;
        @(posedge write_clock);
        #1;
    endtask

    initial begin
        // Reset, three pushes, three pops, underflow, clear
        add(1, 0, 0, 0, 16'h0000, mk(16'h0000, 0, 0, 0));
        add(0, 1, 0, 0, 16'h0010, mk(16'h0010, 1, 0, 0));
        add(0, 1, 0, 0, 16'h0020, mk(16'h0020, 2, 0, 0));
        add(0, 1, 0, 0, 16'h0030, mk(16'h0030, 3, 0, 0));
        add(0, 0, 0, 0, 16'h0000, mk(16'h0030, 3, 0, 0));
        add(0, 0, 1, 0, 16'h0000, mk(16'h0020, 2, 0, 0));
        add(0, 0, 1, 0, 16'h0000, mk(16'h0010, 1, 0, 0));
        add(0, 0, 1, 0, 16'h0000, mk(16'h0000, 0, 0, 0));
        add(0, 0, 1, 0, 16'h0000, mk(16'h0000, 0, 0, 1));
        add(0, 0, 0, 1, 16'h0000, mk(16'h0000, 0, 0, 0));
        // Fill to full, then overflow
        for (int i = 0; i < 16; i++)
            add(0, 1, 0, 0, 16'h0100 + 16'(i), mk(16'h0100 + 16'(i), 5'(i + 1), 0, 0));
        add(0, 1, 0, 0, 16'hBEEF, mk(16'h010F, 16, 1, 0));
        // Error set wins over a simultaneous clear
        add(0, 1, 0, 1, 16'hCAFE, mk(16'h010F, 16, 1, 0));
        add(0, 0, 0, 1, 16'h0000, mk(16'h010F, 16, 0, 0));
        // Pop from full reads the deepest storage slot
        add(0, 0, 1, 0, 16'h0000, mk(16'h010E, 15, 0, 0));
        add(0, 0, 1, 0, 16'h0000, mk(16'h010D, 14, 0, 0));
        // Replace on a two-deep stack, then pop exposes the old second entry
        add(1, 0, 0, 0, 16'h0000, mk(16'h0000, 0, 0, 0));
        add(0, 1, 0, 0, 16'h0011, mk(16'h0011, 1, 0, 0));
        add(0, 1, 0, 0, 16'h0042, mk(16'h0042, 2, 0, 0));
        add(0, 1, 1, 0, 16'h0099, mk(16'h0099, 2, 0, 0));
        add(0, 0, 1, 0, 16'h0000, mk(16'h0011, 1, 0, 0));
        add(0, 0, 1, 0, 16'h0000, mk(16'h0000, 0, 0, 0));
        // Replace when empty behaves as a push
        add(0, 1, 1, 0, 16'h0077, mk(16'h0077, 1, 0, 0));
        add(0, 0, 1, 0, 16'h0000, mk(16'h0000, 0, 0, 0));
        add(0, 0, 1, 0, 16'h0000, mk(16'h0000, 0, 0, 1));
        // Reset wins over a push and clears a set flag
        add(0, 1, 0, 0, 16'h0055, mk(16'h0055, 1, 0, 1));
        add(1, 1, 0, 0, 16'h0066, mk(16'h0000, 0, 0, 0));

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge write_clock);
            reset = vecs[i].rst; push = vecs[i].push; pop = vecs[i].pop;
            clear_err = vecs[i].clr; push_data = vecs[i].data;
            exp_q.push_back(vecs[i].exp);
            @(posedge write_clock);
            #1;
            chk($sformatf("vec%0d", i), sample(), exp_q.pop_front());
        end

        // Return: pop with isReturn on the same edge, PC takes pre-pop TOS
        step(1, 0, 0, 0, 16'h0000, 0);
        step(0, 1, 0, 0, 16'h0011, 0);
        step(0, 1, 0, 0, 16'h0042, 0);
        step(0, 0, 1, 0, 16'h0000, 1);
        n_vec++;
        if (pc !== 16'h0042) begin
            n_miss++;
            $display("FAIL ret_pc: got pc=%h, want pc=%h", pc, 16'h0042);
        end
        chk("ret_tos", sample(), mk(16'h0011, 1, 0, 0));

        // Mid-sequence reset after an overflow-free push and an underflow
        step(0, 1, 0, 0, 16'h0123, 0);
        step(0, 0, 1, 0, 16'h0000, 0);
        step(0, 0, 1, 0, 16'h0000, 0);
        step(0, 0, 1, 0, 16'h0000, 0);
        chk("pre_rst", sample(), mk(16'h0000, 0, 0, 1));
        step(0, 1, 0, 0, 16'h0456, 0);
        step(1, 0, 1, 0, 16'h0000, 0);
        chk("mid_rst", sample(), mk(16'h0000, 0, 0, 0));

        step(0, 0, 0, 0, 16'h0000, 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/return_stack.md
Name: return_stack

Overview:
- Hardware return stack for the stack CPU; its top-of-stack register drives Tbus into the program counter.
- The PC loads Tbus when isReturn is high. The control unit pushes the return address on a call and pops it on a return.
- Register-based top-of-stack (TOS), with a storage array below it.
- Sticky error flags for overflow and underflow, and an optional halt request into haltES.

Parameters:
- DATA_WIDTH, 16, width of each entry and of Tbus.
- DEPTH, 16, maximum number of entries, TOS included. Power of 2, at least 2.
- PTR_WIDTH, 4, equal to log2(DEPTH). Used to index the storage array.

Ports:
- write_clock  in  1  clock; every state change happens on the rising edge.
- reset  in  1  synchronous, active-high; clears the stack and both error flags.
- push  in  1  push push_data this cycle.
- pop  in  1  pop TOS this cycle.
- push_data  in  DATA_WIDTH  value to push (return address PC+1 from the control unit).
- clear_err  in  1  clears the sticky overflow and underflow flags.
- tos  out  DATA_WIDTH  current top of stack; connects to Tbus.
- depth  out  PTR_WIDTH+1  number of valid entries, 0..DEPTH.
- empty  out  1  high when depth==0.
- full  out  1  high when depth==DEPTH.
- overflow  out  1  sticky; set by a push while full.
- underflow  out  1  sticky; set by a pop while empty.
- halt_req  out  1  see Optional Feature.

Behaviour:
- Reset is synchronous and active-high, sampled on write_clock.
  - tos=0, depth=0, overflow=0, underflow=0, halt_req=0.
  - Storage contents are don't-care.
  - Reset wins over every other input in the same cycle, including mid-operation.
- Operation is decoded from {push,pop}, with state updated on the write_clock rising edge. Outputs are registered, so a new value is visible one edge after the request.
- NOP (00): no change.
- PUSH (10), when not full:
  - mem[depth-1] <= tos, only if depth>0.
  - tos <= push_data; depth <= depth+1.
- PUSH when full: no state change except overflow <= 1. The pushed value is dropped.
- POP (01), when depth>1: tos <= mem[depth-2]; depth <= depth-1.
- POP when depth==1: tos <= 0; depth <= 0.
- POP when empty: no state change except underflow <= 1. tos stays 0.
- REPLACE (11), when not empty: tos <= push_data; depth unchanged; storage untouched. Used for a tail call.
- REPLACE when empty: behaves as PUSH.
- Return timing: the control unit asserts pop in the same cycle as isReturn. The PC samples the pre-pop tos on that same edge; after the edge the stack exposes the next entry. No bubble.
- clear_err: clears both flags on the edge. If an error event happens in the same cycle, the set wins.
- empty and full are decoded combinationally from the registered depth.
- Storage index arithmetic is PTR_WIDTH-wide; depth is PTR_WIDTH+1-wide and never wraps.

Optional Feature:
- Macro: RSTACK_ERR_HALT_EN.
- Defined: halt_req = overflow | underflow. It is registered with the flags and is ORed into haltES at the top level, freezing the PC until clear_err or reset.
- Undefined: halt_req is tied to 0. The flags are still reported.

Decomposition:
- Shared package rstack_pkg holds:
  - DATA_WIDTH and DEPTH defaults.
  - Op encoding constants RS_NOP=2'b00, RS_POP=2'b01, RS_PUSH=2'b10, RS_REPLACE=2'b11.
- One sub-module, rstack_mem: a single-write, single-read register array (DEPTH-1 entries), written and read on write_clock.
- The top level holds TOS, depth, the flags and the op decode.

Test Plan:
- Reset, then push 0x0010, 0x0020, 0x0030 on consecutive edges -> tos=0x0030, depth=3, empty=0.
- From that state, pop three times -> tos follows 0x0020, 0x0010, 0x0000; depth follows 2, 1, 0; empty=1.
- Pop while empty -> underflow=1, tos=0, depth=0. clear_err -> underflow=0.
- Push 16 values 0x0100..0x010F -> full=1. Push 0xBEEF -> overflow=1, tos=0x010F, depth=16. With RSTACK_ERR_HALT_EN defined, halt_req=1.
- tos=0x0042 and depth=2, apply push+pop with push_data=0x0099 -> tos=0x0099, depth=2. Then pop -> tos equals the previous second entry.
- Pop with isReturn in the same cycle at a PC-model boundary -> the PC loads 0x0042 (pre-pop tos). Assert reset mid-sequence -> depth=0, tos=0, flags cleared on the next edge.
